// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, operation field encodings, sequencer states.
package alu_pkg;

   // Full 4-bit control codes {a_invert, b_invert, operation[1:0]}
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Operation field (low two bits of the control code)
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bit_alu.sv
// One-bit ALU slice: AND / OR / full-add / pass-less, with optional operand inversion.
// o_set exposes the raw sum bit so the MSB slice can feed set-less-than.
module bit_alu
   import alu_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_less,
   input  logic       i_a_invert,
   input  logic       i_b_invert,
   input  logic       i_carry_in,
   input  logic [1:0] i_operation,
   output logic       o_result,
   output logic       o_carry_out,
   output logic       o_set
);

   logic w_a;
   logic w_b;
   logic w_sum;

   assign w_a   = i_a ^ i_a_invert;
   assign w_b   = i_b ^ i_b_invert;
   assign w_sum = w_a ^ w_b ^ i_carry_in;

   assign o_carry_out = (w_a & w_b) | (w_a & i_carry_in) | (w_b & i_carry_in);
   assign o_set       = w_sum;

   // Select the slice result by operation field
   always_comb begin
      o_result = 1'b0;
      case (i_operation)
         OP_AND:  o_result = w_a & w_b;
         OP_OR:   o_result = w_a | w_b;
         OP_ADD:  o_result = w_sum;
         OP_SLT:  o_result = i_less;
         default: o_result = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: walks one operand bit per clock through a single bit_alu slice,
// LSB first, then finalises SLT, zero, overflow and carry flags in a DONE cycle.
module bit_serial_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_ctrl,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_ctrl;
   logic [IDX_W-1:0] r_idx;
   logic             r_carry;
   logic             r_set;
   logic             r_ovf_msb;
   logic             r_cout_msb;

   logic [WIDTH-1:0] r_result;
   logic             r_valid;
   logic             r_zero;
   logic             r_overflow;
   logic             r_carry_out;

   logic             w_last;
   logic             w_slice_res;
   logic             w_slice_cout;
   logic             w_slice_sum;
   logic [WIDTH-1:0] w_final;

   assign w_last = (r_idx == LAST_IDX);

   // The single shared slice; operands are indexed, not shifted
   bit_alu u_slice (
      .i_a         (r_a[r_idx]),
      .i_b         (r_b[r_idx]),
      .i_less      (1'b0),
      .i_a_invert  (r_ctrl[3]),
      .i_b_invert  (r_ctrl[2]),
      .i_carry_in  (r_carry),
      .i_operation (r_ctrl[1:0]),
      .o_result    (w_slice_res),
      .o_carry_out (w_slice_cout),
      .o_set       (w_slice_sum)
   );

   // SLT overwrites bit 0 with the overflow-corrected sign; other ops keep the serial result
   assign w_final = (r_ctrl[1:0] == OP_SLT) ? {{(WIDTH-1){1'b0}}, r_set} : r_result;

   // ready is withheld during reset so the control unit cannot start into a clearing block
   assign ready     = (r_state == IDLE) && !rst;
   assign valid     = r_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign overflow  = r_overflow;
   assign carry_out = r_carry_out;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand latch, bit walk and flag finalisation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= 4'b0000;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_set       <= 1'b0;
         r_ovf_msb   <= 1'b0;
         r_cout_msb  <= 1'b0;
         r_result    <= '0;
         r_valid     <= 1'b0;
         r_zero      <= 1'b0;
         r_overflow  <= 1'b0;
         r_carry_out <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_ctrl   <= alu_ctrl;
                  r_idx    <= '0;
                  r_carry  <= alu_ctrl[2];
                  r_result <= '0;
               end
            end
            RUN: begin
               r_result[r_idx] <= w_slice_res;
               r_carry         <= w_slice_cout;
               if (w_last) begin
                  // r_carry is the carry into the MSB at this point
                  r_ovf_msb  <= r_carry ^ w_slice_cout;
                  r_cout_msb <= w_slice_cout;
                  r_set      <= w_slice_sum ^ (r_carry ^ w_slice_cout);
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            DONE: begin
               r_result    <= w_final;
               r_zero      <= (w_final == '0);
               r_overflow  <= (r_ctrl[1:0] == OP_ADD) ? r_ovf_msb  : 1'b0;
               r_carry_out <= (r_ctrl[1:0] == OP_ADD) ? r_cout_msb : 1'b0;
               r_valid     <= 1'b1;
            end
            default: begin
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: directed cases plus randomized operations,
// checked against an arithmetic reference model.
module tb_bit_serial_alu;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   alu_ctrl = 4'b0000;
   logic         valid;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic         carry_out;

   int n_cmp = 0;
   int n_err = 0;

   bit_serial_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ready     (ready),
      .a         (a),
      .b         (b),
      .alu_ctrl  (alu_ctrl),
      .valid     (valid),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic on the (optionally inverted) operands
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [3:0] c, output logic [W-1:0] r,
                                 output logic z, output logic o, output logic co);
      logic [W-1:0] aa;
      logic [W-1:0] bb;
      logic [W:0]   s;
      logic         ovf;
      aa  = c[3] ? ~ma : ma;
      bb  = c[2] ? ~mb : mb;
      s   = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c[2]};
      ovf = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
      case (c[1:0])
         2'b00:   r = aa & bb;
         2'b01:   r = aa | bb;
         2'b10:   r = s[W-1:0];
         default: r = (s[W-1] ^ ovf) ? {{(W-1){1'b0}}, 1'b1} : '0;
      endcase
      o  = (c[1:0] == 2'b10) ? ovf  : 1'b0;
      co = (c[1:0] == 2'b10) ? s[W] : 1'b0;
      z  = (r == '0);
   endfunction

   // Issue one op (block must be idle, called away from the edge); returns #1 after the valid edge.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [3:0] tc, input bit hold, input string nm);
      logic [W-1:0] er;
      logic ez, eo, ec;
      int   cnt;
      bit   busy_rdy;
      model(ta, tb_, tc, er, ez, eo, ec);
      chk({nm, "_ready_idle"}, 64'(ready), 64'(1'b1));
      a = ta; b = tb_; alu_ctrl = tc; start = 1'b1;
      @(posedge clk); #1;
      busy_rdy = ready;
      chk({nm, "_clear_on_accept"}, 64'(result), 64'(0));
      start = hold;
      cnt = 0;
      while (cnt < W + 6) begin
         if (hold) begin
            a = $urandom; b = $urandom; alu_ctrl = 4'($urandom);
         end
         @(posedge clk); #1;
         cnt++;
         if (valid) break;
         busy_rdy |= ready;
      end
      start = 1'b0;
      chk({nm, "_latency"}, 64'(cnt), 64'(W + 1));
      chk({nm, "_busy_ready"}, 64'(busy_rdy), 64'(1'b0));
      chk({nm, "_result"}, 64'(result), 64'(er));
      chk({nm, "_flags"}, 64'({zero, overflow, carry_out}), 64'({ez, eo, ec}));
   endtask

   // Check the pulse is one cycle and outputs hold afterwards
   task automatic after_valid(input string nm);
      logic [W-1:0] keep;
      keep = result;
      @(posedge clk); #1;
      chk({nm, "_valid_drop"}, 64'(valid), 64'(1'b0));
      chk({nm, "_hold"}, 64'(result), 64'(keep));
   endtask

   initial begin
      logic [3:0] rc;
      // Reset state
      @(posedge clk); #1;
      chk("rst_ready_low", 64'(ready), 64'(1'b0));
      @(posedge clk); #1;
      chk("rst_outputs", 64'({valid, zero, overflow, carry_out}), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 64'(ready), 64'(1'b1));

      // Directed cases
      run_op(32'h7FFF_FFFF, 32'h1, ALU_ADD, 1'b0, "add_ovf");
      chk("add_ovf_exact", 64'({result, zero, overflow, carry_out}),
          64'({32'h8000_0000, 1'b0, 1'b1, 1'b0}));
      after_valid("add_ovf");
      run_op(32'd5, 32'd5, ALU_SUB, 1'b0, "sub_eq");
      chk("sub_eq_exact", 64'({result, zero, overflow, carry_out}),
          64'({32'h0, 1'b1, 1'b0, 1'b1}));
      after_valid("sub_eq");
      run_op(32'hFFFF_FFFF, 32'h1, ALU_SLT, 1'b0, "slt_neg");
      chk("slt_neg_exact", 64'(result), 64'(32'h1));
      after_valid("slt_neg");
      run_op(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT, 1'b0, "slt_ovf");
      chk("slt_ovf_exact", 64'({result, overflow}), 64'({32'h0, 1'b0}));
      after_valid("slt_ovf");
      run_op(32'h0, 32'h0, ALU_NOR, 1'b0, "nor");
      chk("nor_exact", 64'(result), 64'(32'hFFFF_FFFF));
      after_valid("nor");
      run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 1'b0, "and");
      chk("and_exact", 64'(result), 64'(32'h00F0_00F0));
      after_valid("and");
      run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR, 1'b0, "or");
      chk("or_exact", 64'({result, zero}), 64'({32'hFFF0_FFF0, 1'b0}));
      after_valid("or");

      // start held high through the run with changing operands
      run_op(32'h1234_5678, 32'h1111_1111, ALU_SUB, 1'b1, "hold_start");
      after_valid("hold_start");

      // Back-to-back: new start on the valid cycle
      run_op(32'd100, 32'd23, ALU_ADD, 1'b0, "b2b_first");
      run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, ALU_SUB, 1'b0, "b2b_second");
      after_valid("b2b_second");

      // Reset mid-run at idx=10
      a = 32'd7; b = 32'd9; alu_ctrl = ALU_ADD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready_low", 64'(ready), 64'(1'b0));
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_outputs", 64'({result, valid, zero, overflow, carry_out}), 64'(0));
      chk("midrst_ready", 64'(ready), 64'(1'b1));
      begin
         bit seen;
         seen = 1'b0;
         repeat (W + 4) begin
            @(posedge clk); #1;
            seen |= valid;
         end
         chk("midrst_no_valid", 64'(seen), 64'(1'b0));
      end
      run_op(32'd2, 32'd3, ALU_ADD, 1'b0, "post_rst_add");
      chk("post_rst_add_exact", 64'(result), 64'(32'd5));
      after_valid("post_rst_add");

      // Randomized operations over all 16 control codes
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = (i % 5 == 0) ? ra : 32'($urandom);
         rc = 4'($urandom);
         run_op(ra, rb, rc, bit'($urandom_range(0, 1)), "rand");
         if (i % 3 != 0) begin
            after_valid("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
